register_writeback_arbiter: RTL



---
 rtl/register_writeback_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/register_writeback_arbiter.sv
// Writeback arbiter: two producers with one-entry holding slots share the single registered
// register-file write port under round-robin. Optional WRITEBACK_PENDING_MASK_EN adds a pending-register mask.
module register_writeback_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int SELECT_WIDTH = 5,
   parameter bit DROP_ZERO    = 1'b1
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   input  logic                    in_valid_0,
   output logic                    out_ready_0,
   input  logic [SELECT_WIDTH-1:0] in_write_register_select_0,
   input  logic [DATA_WIDTH-1:0]   in_write_data_0,
   input  logic                    in_valid_1,
   output logic                    out_ready_1,
   input  logic [SELECT_WIDTH-1:0] in_write_register_select_1,
   input  logic [DATA_WIDTH-1:0]   in_write_data_1,
`ifdef WRITEBACK_PENDING_MASK_EN
   output logic [2**SELECT_WIDTH-1:0] out_pending_mask,
`endif
   output logic                    out_write_enable,
   output logic [SELECT_WIDTH-1:0] out_write_register_select,
   output logic [DATA_WIDTH-1:0]   out_write_data,
   output logic                    out_busy
);

   logic                    slot_valid_0, slot_valid_1;
   logic [SELECT_WIDTH-1:0] slot_sel_0, slot_sel_1;
   logic [DATA_WIDTH-1:0]   slot_data_0, slot_data_1;
   logic                    last_grant;
   logic                    grant_0, grant_1;
   logic                    accept_0, accept_1;
   logic                    drop_0, drop_1;

   // Round-robin over occupied slots only; on a tie the slot that did not win last time goes.
   assign grant_0 = slot_valid_0 && (!slot_valid_1 || last_grant);
   assign grant_1 = slot_valid_1 && (!slot_valid_0 || !last_grant);

   // Handshake: a transfer happens on a posedge where in_valid_i && out_ready_i; ready is a
   // function of slot state only (empty, or being drained this cycle), never of in_valid_i.
   assign out_ready_0 = !slot_valid_0 || grant_0;
   assign out_ready_1 = !slot_valid_1 || grant_1;

   assign accept_0 = in_valid_0 && out_ready_0;
   assign accept_1 = in_valid_1 && out_ready_1;
   assign drop_0   = DROP_ZERO && (in_write_register_select_0 == '0);
   assign drop_1   = DROP_ZERO && (in_write_register_select_1 == '0);

   assign out_busy = slot_valid_0 || slot_valid_1 || out_write_enable;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         slot_valid_0 <= 1'b0;
         slot_sel_0   <= '0;
         slot_data_0  <= '0;
      end else if (accept_0 && !drop_0) begin
         slot_valid_0 <= 1'b1;
         slot_sel_0   <= in_write_register_select_0;
         slot_data_0  <= in_write_data_0;
      end else if (grant_0) begin
         slot_valid_0 <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         slot_valid_1 <= 1'b0;
         slot_sel_1   <= '0;
         slot_data_1  <= '0;
      end else if (accept_1 && !drop_1) begin
         slot_valid_1 <= 1'b1;
         slot_sel_1   <= in_write_register_select_1;
         slot_data_1  <= in_write_data_1;
      end else if (grant_1) begin
         slot_valid_1 <= 1'b0;
      end
   end

   // Select and data hold their last values when idle; only the enable drops.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         last_grant                <= 1'b1;
         out_write_enable          <= 1'b0;
         out_write_register_select <= '0;
         out_write_data            <= '0;
      end else if (grant_0) begin
         last_grant                <= 1'b0;
         out_write_enable          <= 1'b1;
         out_write_register_select <= slot_sel_0;
         out_write_data            <= slot_data_0;
      end else if (grant_1) begin
         last_grant                <= 1'b1;
         out_write_enable          <= 1'b1;
         out_write_register_select <= slot_sel_1;
         out_write_data            <= slot_data_1;
      end else begin
         out_write_enable          <= 1'b0;
      end
   end

`ifdef WRITEBACK_PENDING_MASK_EN
   always_comb begin
      out_pending_mask = '0;
      if (slot_valid_0)     out_pending_mask[slot_sel_0] = 1'b1;
      if (slot_valid_1)     out_pending_mask[slot_sel_1] = 1'b1;
      if (out_write_enable) out_pending_mask[out_write_register_select] = 1'b1;
      if (DROP_ZERO)        out_pending_mask[0] = 1'b0;
   end
`endif

endmodule
